// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t          state;
   logic [2:0]      op;
   logic            neg;
   logic            neg_r;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] opnd;

   logic            sa;
   logic            sb;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] min_val;
   logic            div_zero;
   logic            ovf;
   logic [XLEN-1:0] spec_res;

   logic [XLEN:0]     sum;
   logic [XLEN:0]     trial;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   acc_n;
   logic [XLEN-1:0]   lo_n;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   q_s;
   logic [XLEN-1:0]   r_s;
   logic [XLEN-1:0]   fin;

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign min_val  = {1'b1, {(XLEN-1){1'b0}}};

   always_comb begin
      sa = 1'b0;
      sb = 1'b0;
      unique case (funct3)
         3'b001, 3'b100, 3'b110: begin
            sa = 1'b1;
            sb = 1'b1;
         end
         3'b010:  sa = 1'b1;
         default: begin end
      endcase
      a_neg    = sa & op_a[XLEN-1];
      b_neg    = sb & op_b[XLEN-1];
      a_mag    = a_neg ? -op_a : op_a;
      b_mag    = b_neg ? -op_b : op_b;
      div_zero = funct3[2] & (op_b == '0);
      ovf      = funct3[2] & ~funct3[0]
               & (op_a == min_val) & (&op_b);
      spec_res = '0;
      if (div_zero)
         spec_res = funct3[1] ? op_a : '1;
      else if (ovf)
         spec_res = funct3[1] ? '0 : op_a;
   end

   // acc/lo hold the product halves for multiply, remainder/quotient for divide
   always_comb begin
      sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
      trial = {acc, lo[XLEN-1]};
      diff  = trial - {1'b0, opnd};
      if (op[2]) begin
         acc_n = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
         lo_n  = {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
         acc_n = sum[XLEN:1];
         lo_n  = {sum[0], lo[XLEN-1:1]};
      end
      prod   = {acc_n, lo_n};
      prod_s = neg ? -prod : prod;
      q_s    = neg ? -lo_n : lo_n;
      r_s    = neg_r ? -acc_n : acc_n;
      if (op[2])
         fin = op[1] ? r_s : q_s;
      else if (op[1:0] == 2'b00)
         fin = prod_s[XLEN-1:0];
      else
         fin = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         op        <= '0;
         neg       <= 1'b0;
         neg_r     <= 1'b0;
         acc       <= '0;
         lo        <= '0;
         opnd      <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op    <= funct3;
                  neg   <= a_neg ^ b_neg;
                  neg_r <= a_neg & (funct3 == 3'b110);
                  acc   <= '0;
                  lo    <= funct3[2] ? a_mag : b_mag;
                  opnd  <= funct3[2] ? b_mag : a_mag;
                  if (div_zero | ovf) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= spec_res;
                  end else begin
                     state <= CALC;
                     cnt   <= CW'(XLEN);
                  end
               end
            end
            CALC: begin
               acc <= acc_n;
               lo  <= lo_n;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= fin;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Directed bench for muldiv_unit: results, latency, back-pressure, kill.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .funct3   (funct3),
      .op_a     (op_a),
      .op_b     (op_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .busy     (busy)
   );

   // lat = cycle offset (from the accept edge) in which out_valid is first seen
   task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat);
      funct3   = f;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a     = 32'hDEAD_BEEF;
      op_b     = 32'h1234_5678;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b expected 100",
                  {in_ready, out_valid, busy});
      end
      n_cmp++;
      if (result !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_result: got %h expected 0", result);
      end
   endtask

   task automatic test_mul_timing;
      logic [31:0] r;
      int l;
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, l);
      n_cmp++;
      if (r !== 32'hFFFF_FFEB) begin
         n_bad++;
         $display("FAIL mul_result: got %h expected ffffffeb", r);
      end
      n_cmp++;
      if (l !== 33) begin
         n_bad++;
         $display("FAIL mul_latency: got %0d expected 33", l);
      end
      consume();
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mul_handoff: in_ready got %b expected 1", in_ready);
      end
   endtask

   task automatic test_high_mul;
      logic [2:0]  f[3] = '{3'b001, 3'b011, 3'b010};
      logic [31:0] a[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] b[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] e[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] r;
      int l;
      for (int i = 0; i < 3; i++) begin
         run_op(f[i], a[i], b[i], r, l);
         n_cmp++;
         if (r !== e[i] || l !== 33) begin
            n_bad++;
            $display("FAIL high_mul[%0d]: got %h lat %0d expected %h lat 33",
                     i, r, l, e[i]);
         end
         consume();
      end
   endtask

   task automatic test_div;
      logic [2:0]  f[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] e[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      logic [31:0] r;
      int l;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], r, l);
         n_cmp++;
         if (r !== e[i] || l !== 33) begin
            n_bad++;
            $display("FAIL div[%0d]: got %h lat %0d expected %h lat 33",
                     i, r, l, e[i]);
         end
         consume();
      end
   endtask

   task automatic test_special;
      logic [2:0]  f[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
      logic [31:0] a[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] e[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      logic [31:0] r;
      int l;
      for (int i = 0; i < 4; i++) begin
         run_op(f[i], a[i], b[i], r, l);
         n_cmp++;
         if (r !== e[i] || l !== 1) begin
            n_bad++;
            $display("FAIL special[%0d]: got %h lat %0d expected %h lat 1",
                     i, r, l, e[i]);
         end
         consume();
      end
   endtask

   task automatic test_backpressure;
      int l;
      funct3   = 3'b101;
      op_a     = 32'd100;
      op_b     = 32'd7;
      in_valid = 1'b1;
      @(posedge clk); #1;
      funct3 = 3'b000;
      op_a   = 32'd3;
      op_b   = 32'd3;
      l = 1;
      while (!out_valid && l < 200) begin
         @(posedge clk); #1;
         l++;
      end
      n_cmp++;
      if (result !== 32'd14 || l !== 33) begin
         n_bad++;
         $display("FAIL bp_result: got %h lat %0d expected 0000000e lat 33",
                  result, l);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (result !== 32'd14 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got %h rdy %b vld %b expected 0000000e 0 1",
                     i, result, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      consume();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_handoff: rdy %b vld %b expected 1 0",
                  in_ready, out_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_no_stray: busy got %b expected 0", busy);
      end
   endtask

   task automatic test_kill(input bit use_rst);
      logic [31:0] r;
      int l;
      bit seen;
      funct3   = 3'b000;
      op_a     = 32'd9;
      op_b     = 32'd9;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      flush = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_bad++;
         $display("FAIL kill_ctrl(rst=%0d): got %b expected 100",
                  use_rst, {in_ready, out_valid, busy});
      end
      if (use_rst) begin
         n_cmp++;
         if (result !== 32'h0) begin
            n_bad++;
            $display("FAIL kill_result: got %h expected 0", result);
         end
      end else begin
         in_valid = 1'b1;
         flush    = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         flush    = 1'b0;
         n_cmp++;
         if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_blocks_accept: busy got %b expected 0", busy);
         end
      end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL kill_no_valid(rst=%0d): got %b expected 0",
                  use_rst, seen);
      end
      run_op(use_rst ? 3'b111 : 3'b101, 32'd100, 32'd7, r, l);
      n_cmp++;
      if (r !== (use_rst ? 32'd2 : 32'd14) || l !== 33) begin
         n_bad++;
         $display("FAIL kill_next_op(rst=%0d): got %h lat %0d expected %h lat 33",
                  use_rst, r, l, use_rst ? 32'd2 : 32'd14);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_mul_timing();
      test_high_mul();
      test_div();
      test_special();
      test_backpressure();
      test_kill(1'b0);
      test_kill(1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
